ppg_pre_sched: RTL and testbench
================================

# ppg_pre_sched

Sequencing controller for the PPG pre-processing pipeline (HPF → LPF → DownSampler). It generates the pipeline's single sample-enable strobe from the system clock and flushes the filters on start. It discards decimated outputs while the filters settle, then buffers valid decimated samples in a small FIFO behind a ready/valid interface for the downstream feature-extraction stage.

## Interface
Parameters:
- Width, 10: signed sample width; matches the pipeline's Width.
- CLK_DIV, 1000: clk cycles per input sample, i.e. the enable period. Legal range ≥ 2.
- SETTLE, 64: number of decimated outputs discarded after each start. Legal range ≥ 1.
- DEPTH, 4: output FIFO depth. Must be a power of two, ≥ 2.

Ports:
- clk, input, 1: single clock; all logic on the rising edge.
- rst, input, 1: synchronous, active-high reset.
- start, input, 1: one-cycle request to begin acquisition.
- stop, input, 1: one-cycle request to end acquisition.
- pp_en, output, 1: enable strobe to the pipeline `en`; one cycle high per sample period.
- pp_clr, output, 1: one-cycle flush pulse to the pipeline; the top level combines it into the filter/decimator reset.
- pp_data, input, Width: decimated sample from the pipeline.
- pp_valid, input, 1: pipeline output-valid.
- out_data, output, Width: FIFO head sample. Signed.
- out_valid, output, 1: FIFO non-empty.
- out_ready, input, 1: downstream accept.
- busy, output, 1: state is not IDLE.
- settled, output, 1: state is RUN.
- overflow, output, 1: sticky; a RUN sample was dropped because the FIFO was full.

## Operation
- FSM states: IDLE, SETTLE, RUN.
- Transitions:
  - IDLE → SETTLE on start = 1 with stop = 0.
  - SETTLE → RUN on the pp_valid that brings the discard count to SETTLE.
  - SETTLE/RUN → IDLE on stop = 1.
  - start is ignored in SETTLE/RUN.
  - start and stop in the same cycle: stop wins; from IDLE, remain in IDLE.
- Accepting start (IDLE → SETTLE) does all of the following in one step:
  - asserts pp_clr for that cycle;
  - zeroes the divider and discard counters;
  - empties the FIFO;
  - clears overflow.
- Divider (div_cnt, range 0..CLK_DIV-1):
  - counts only in SETTLE/RUN;
  - pp_en = 1 exactly in cycles where div_cnt == CLK_DIV-1; div_cnt wraps to 0 in the same cycle;
  - held at 0 in IDLE.
- SETTLE: each pp_valid = 1 increments disc_cnt. The sample is never written to the FIFO, including the final discarded one.
- RUN: pp_valid = 1 pushes pp_data into the FIFO.
  - If the FIFO is full and no pop occurs that cycle, the sample is dropped and overflow is set.
  - Push and pop in the same cycle while full: both are accepted, occupancy stays DEPTH, overflow unchanged.
- pp_valid in IDLE is ignored.
- Pop: out_valid & out_ready. out_data shows the oldest entry and stays stable while out_valid = 1 and out_ready = 0.
- stop retains FIFO contents; they remain drainable in IDLE. Only the next accepted start empties the FIFO.
- Pointers are log2(DEPTH)+1 bits with natural wrap. Full and empty are derived from the MSB and pointer equality.

## Timing
- All outputs are 0 after reset: state IDLE, counters 0, FIFO empty, out_data = 0.
- rst asserted mid-acquisition: in the next cycle the state is IDLE, FIFO empty, and pp_en, pp_clr, busy, settled, overflow are all 0. In-flight samples are lost.
- Start latency: pp_clr is high in the cycle start is sampled. busy rises the following cycle. The first pp_en occurs CLK_DIV cycles after the start cycle.
- pp_en period: exactly CLK_DIV cycles, with no jitter, across SETTLE → RUN.
- settled rises the cycle after the SETTLE-th discarded pp_valid.
- Push → out_valid: 1 cycle (registered FIFO write). Pop → out_valid deassertion on the last entry: 1 cycle.
- stop: busy, settled, and pp_en are low from the next cycle onward. A pp_en coincident with the stop cycle is still issued.
- pp_clr is never asserted except on an accepted start.

## Test plan
All scenarios use CLK_DIV = 4, SETTLE = 3, DEPTH = 4.
- Reset/idle: hold rst for 3 cycles, then idle 20 cycles with pp_valid toggling → all outputs 0, FIFO stays empty.
- Start/divider: start at cycle t → pp_clr high at t, busy at t+1, pp_en at t+4, t+8, t+12 …; start again while busy → no new pp_clr, pp_en phase unchanged.
- Settle/run: drive pp_valid with values 5, 6, 7, 8, −3 → first three discarded, settled rises after 7; FIFO outputs 8 then −3 (sign preserved) with out_ready = 1.
- Backpressure/overflow: in RUN, out_ready = 0, push 10, 11, 12, 13, 14 → 14 dropped, overflow = 1, occupancy 4. Push 15 with a simultaneous pop → 10 popped, 15 accepted, overflow stays 1. Drain order: 11, 12, 13, 15.
- Stop/retain/restart: stop with 2 entries held → busy = 0 next cycle, entries still drainable. start then stop in the same cycle → stays IDLE. A later start → FIFO empty, overflow cleared.
- Mid-run reset: rst asserted in RUN with 3 entries held → next cycle IDLE, out_valid = 0, pp_en = 0.

Source files
------------

// File: rtl/ppg_pre_sched.sv
// Sequencing controller for the PPG pre-processing pipeline: sample-enable
// divider, flush on start, settle-time discard and a small output FIFO.
module ppg_pre_sched #(
  parameter int Width   = 10,
  parameter int CLK_DIV = 1000,
  parameter int SETTLE  = 64,
  parameter int DEPTH   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  output logic             pp_en,
  output logic             pp_clr,
  input  logic [Width-1:0] pp_data,
  input  logic             pp_valid,
  output logic [Width-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy,
  output logic             settled,
  output logic             overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int CW = $clog2(CLK_DIV);
  localparam int SW = $clog2(SETTLE + 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_RUN
  } state_t;

  state_t          state_q;
  logic [CW-1:0]   divCnt_q;
  logic [SW-1:0]   discCnt_q;
  logic            overflow_q;
  logic [PW-1:0]   wrPtr_q, wrPtr_d;
  logic [PW-1:0]   rdPtr_q, rdPtr_d;
  logic [Width-1:0] mem_q [DEPTH];

  logic startAcc;
  logic fifoFull;
  logic fifoEmpty;
  logic pop;
  logic runSample;
  logic push;

  // Start is only honoured from IDLE, and a coincident stop cancels it.
  assign startAcc  = (state_q == ST_IDLE) && start && !stop;
  assign pp_clr    = startAcc;
  assign pp_en     = (state_q != ST_IDLE) && (divCnt_q == CW'(CLK_DIV - 1));
  assign busy      = (state_q != ST_IDLE);
  assign settled   = (state_q == ST_RUN);
  assign overflow  = overflow_q;

  assign fifoEmpty = (wrPtr_q == rdPtr_q);
  assign fifoFull  = (wrPtr_q[AW] != rdPtr_q[AW]) && (wrPtr_q[AW-1:0] == rdPtr_q[AW-1:0]);
  assign out_valid = !fifoEmpty;
  assign out_data  = fifoEmpty ? '0 : mem_q[rdPtr_q[AW-1:0]];

  // A full FIFO still takes a sample when the head leaves in the same cycle.
  assign pop       = out_valid && out_ready;
  assign runSample = (state_q == ST_RUN) && pp_valid && !stop;
  assign push      = runSample && (!fifoFull || pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      divCnt_q   <= '0;
      discCnt_q  <= '0;
      overflow_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (startAcc) begin
            state_q    <= ST_SETTLE;
            divCnt_q   <= '0;
            discCnt_q  <= '0;
            overflow_q <= 1'b0;
          end
        end
        ST_SETTLE, ST_RUN: begin
          if (stop) begin
            state_q  <= ST_IDLE;
            divCnt_q <= '0;
          end else begin
            divCnt_q <= pp_en ? '0 : divCnt_q + 1'b1;
            if ((state_q == ST_SETTLE) && pp_valid) begin
              discCnt_q <= discCnt_q + 1'b1;
              if (discCnt_q == SW'(SETTLE - 1)) state_q <= ST_RUN;
            end
            if (runSample && fifoFull && !pop) overflow_q <= 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    wrPtr_d = wrPtr_q;
    rdPtr_d = rdPtr_q;
    if (startAcc) begin
      wrPtr_d = '0;
      rdPtr_d = '0;
    end else begin
      if (push) wrPtr_d = wrPtr_q + 1'b1;
      if (pop)  rdPtr_d = rdPtr_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
    end else begin
      wrPtr_q <= wrPtr_d;
      rdPtr_q <= rdPtr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wrPtr_q[AW-1:0]] <= pp_data;
  end

endmodule

// File: tb/tb_ppg_pre_sched.sv
// Directed bench for ppg_pre_sched with CLK_DIV=4, SETTLE=3, DEPTH=4.
module tb_ppg_pre_sched;

  localparam int Width = 10;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic             stop = 1'b0;
  logic             ppEn;
  logic             ppClr;
  logic [Width-1:0] ppData = '0;
  logic             ppValid = 1'b0;
  logic [Width-1:0] outData;
  logic             outValid;
  logic             outReady = 1'b0;
  logic             busy;
  logic             settled;
  logic             overflow;

  int testsRun = 0;
  int testsFailed = 0;

  ppg_pre_sched #(
    .Width(Width), .CLK_DIV(4), .SETTLE(3), .DEPTH(4)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop),
    .pp_en(ppEn), .pp_clr(ppClr), .pp_data(ppData), .pp_valid(ppValid),
    .out_data(outData), .out_valid(outValid), .out_ready(outReady),
    .busy(busy), .settled(settled), .overflow(overflow)
  );

  always #5 clk = ~clk;

  // Every comparison funnels through here so the counts stay honest.
  task automatic checkOutput(input string tag, input int observed, input int expected);
    testsRun++;
    if (observed !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  // Drives all inputs at once, then lets combinational outputs settle.
  task automatic applyStimulus(input logic s, input logic p, input logic v,
                               input int d, input logic r);
    start    = s;
    stop     = p;
    ppValid  = v;
    ppData   = d[Width-1:0];
    outReady = r;
    #1;
  endtask

  task automatic pushSample(input int d);
    applyStimulus(1'b0, 1'b0, 1'b1, d, 1'b0);
    nextCycle();
    applyStimulus(1'b0, 1'b0, 1'b0, 0, 1'b0);
  endtask

  task automatic popExpect(input string tag, input int d);
    checkOutput({tag, "_valid"}, int'(outValid), 1);
    checkOutput({tag, "_data"}, int'($signed(outData)), d);
    applyStimulus(1'b0, 1'b0, 1'b0, 0, 1'b1);
    nextCycle();
    applyStimulus(1'b0, 1'b0, 1'b0, 0, 1'b0);
  endtask

  initial begin
    int expOrder[4];

    // Reset and idle: pp_valid toggling in IDLE must be ignored.
    repeat (3) nextCycle();
    rst = 1'b0;
    #1;
    checkOutput("rst_pp_en", int'(ppEn), 0);
    checkOutput("rst_pp_clr", int'(ppClr), 0);
    checkOutput("rst_out_valid", int'(outValid), 0);
    checkOutput("rst_out_data", int'(outData), 0);
    checkOutput("rst_busy", int'(busy), 0);
    checkOutput("rst_settled", int'(settled), 0);
    checkOutput("rst_overflow", int'(overflow), 0);
    for (int i = 0; i < 20; i++) begin
      applyStimulus(1'b0, 1'b0, i[0], 100 + i, 1'b0);
      checkOutput("idle_pp_en", int'(ppEn), 0);
      checkOutput("idle_busy", int'(busy), 0);
      checkOutput("idle_out_valid", int'(outValid), 0);
      nextCycle();
    end
    applyStimulus(1'b0, 1'b0, 1'b0, 0, 1'b0);
    checkOutput("idle_end_out_valid", int'(outValid), 0);

    // Start and divider phase; a second start while busy changes nothing.
    applyStimulus(1'b1, 1'b0, 1'b0, 0, 1'b0);
    checkOutput("start_pp_clr", int'(ppClr), 1);
    checkOutput("start_busy_t0", int'(busy), 0);
    nextCycle();
    applyStimulus(1'b0, 1'b0, 1'b0, 0, 1'b0);
    checkOutput("start_busy_t1", int'(busy), 1);
    checkOutput("start_settled_t1", int'(settled), 0);
    for (int k = 1; k <= 12; k++) begin
      applyStimulus((k == 6) ? 1'b1 : 1'b0, 1'b0, 1'b0, 0, 1'b0);
      checkOutput($sformatf("div_pp_en_t%0d", k), int'(ppEn), (k % 4 == 0) ? 1 : 0);
      checkOutput("div_pp_clr", int'(ppClr), 0);
      nextCycle();
    end
    applyStimulus(1'b0, 1'b0, 1'b0, 0, 1'b0);

    // Settle discards 5, 6, 7; then 8 and -3 come out in order.
    for (int i = 5; i <= 7; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b1, i, 1'b0);
      checkOutput("settle_settled_low", int'(settled), 0);
      nextCycle();
    end
    applyStimulus(1'b0, 1'b0, 1'b0, 0, 1'b0);
    checkOutput("settle_settled_high", int'(settled), 1);
    checkOutput("settle_no_discard_push", int'(outValid), 0);
    pushSample(8);
    popExpect("run_first", 8);
    checkOutput("run_empty_after_pop", int'(outValid), 0);
    pushSample(-3);
    popExpect("run_signed", -3);
    checkOutput("run_empty_again", int'(outValid), 0);

    // Backpressure fills the FIFO; 14 is dropped and overflow sets.
    for (int i = 10; i <= 13; i++) pushSample(i);
    checkOutput("bp_overflow_before", int'(overflow), 0);
    pushSample(14);
    checkOutput("bp_overflow_set", int'(overflow), 1);
    checkOutput("bp_head", int'($signed(outData)), 10);
    applyStimulus(1'b0, 1'b0, 1'b1, 15, 1'b1);
    nextCycle();
    applyStimulus(1'b0, 1'b0, 1'b0, 0, 1'b0);
    checkOutput("bp_overflow_sticky", int'(overflow), 1);
    expOrder = '{11, 12, 13, 15};
    for (int i = 0; i < 4; i++) popExpect($sformatf("bp_drain%0d", i), expOrder[i]);
    checkOutput("bp_drained", int'(outValid), 0);

    // Stop keeps the FIFO drainable; start with stop is ignored.
    pushSample(20);
    pushSample(21);
    applyStimulus(1'b0, 1'b1, 1'b0, 0, 1'b0);
    nextCycle();
    applyStimulus(1'b0, 1'b0, 1'b0, 0, 1'b0);
    checkOutput("stop_busy", int'(busy), 0);
    checkOutput("stop_settled", int'(settled), 0);
    checkOutput("stop_pp_en", int'(ppEn), 0);
    checkOutput("stop_overflow_kept", int'(overflow), 1);
    popExpect("stop_drain", 20);
    applyStimulus(1'b1, 1'b1, 1'b0, 0, 1'b0);
    checkOutput("startstop_pp_clr", int'(ppClr), 0);
    nextCycle();
    applyStimulus(1'b0, 1'b0, 1'b0, 0, 1'b0);
    checkOutput("startstop_busy", int'(busy), 0);
    checkOutput("startstop_kept", int'($signed(outData)), 21);
    applyStimulus(1'b1, 1'b0, 1'b0, 0, 1'b0);
    checkOutput("restart_pp_clr", int'(ppClr), 1);
    nextCycle();
    applyStimulus(1'b0, 1'b0, 1'b0, 0, 1'b0);
    checkOutput("restart_busy", int'(busy), 1);
    checkOutput("restart_fifo_empty", int'(outValid), 0);
    checkOutput("restart_overflow_clr", int'(overflow), 0);

    // Reach RUN with three entries, then reset mid-acquisition.
    for (int i = 0; i < 3; i++) pushSample(50 + i);
    checkOutput("mid_settled", int'(settled), 1);
    checkOutput("mid_empty", int'(outValid), 0);
    for (int i = 1; i <= 3; i++) pushSample(i);
    checkOutput("mid_held", int'(outValid), 1);
    rst = 1'b1;
    nextCycle();
    checkOutput("midrst_busy", int'(busy), 0);
    checkOutput("midrst_out_valid", int'(outValid), 0);
    checkOutput("midrst_pp_en", int'(ppEn), 0);
    checkOutput("midrst_settled", int'(settled), 0);
    checkOutput("midrst_out_data", int'(outData), 0);
    rst = 1'b0;
    nextCycle();

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
